// File: rtl/picorv32_mem_arbiter.sv
// Two-master round-robin arbiter for the picorv32 native memory bus, with a slave watchdog.
// Latency: one arbitration cycle (request seen in IDLE -> slave valid next cycle), then slave latency.
// Backpressure: the granted master waits on s_mem_ready_i; the other master sees ready=0 until its grant.
module picorv32_mem_arbiter #(
    parameter int TIMEOUT   = 255,
    parameter int TIMEOUT_W = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_mem_valid_i,
    input  logic        m0_mem_instr_i,
    input  logic [31:0] m0_mem_addr_i,
    input  logic [31:0] m0_mem_wdata_i,
    input  logic [3:0]  m0_mem_wstrb_i,
    output logic        m0_mem_ready_o,
    output logic [31:0] m0_mem_rdata_o,
    input  logic        m1_mem_valid_i,
    input  logic        m1_mem_instr_i,
    input  logic [31:0] m1_mem_addr_i,
    input  logic [31:0] m1_mem_wdata_i,
    input  logic [3:0]  m1_mem_wstrb_i,
    output logic        m1_mem_ready_o,
    output logic [31:0] m1_mem_rdata_o,
    output logic        s_mem_valid_o,
    output logic        s_mem_instr_o,
    output logic [31:0] s_mem_addr_o,
    output logic [31:0] s_mem_wdata_o,
    output logic [3:0]  s_mem_wstrb_o,
    input  logic        s_mem_ready_i,
    input  logic [31:0] s_mem_rdata_i,
    output logic [1:0]  grant_o,
    output logic        busy_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam bit                   WD_EN   = (TIMEOUT != 0);
    localparam logic [TIMEOUT_W-1:0] TO_VAL  = TIMEOUT_W'(TIMEOUT);
    localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

    state_t               state_q, state_d;
    logic                 last_q, last_d;     // last served master: 0 = m0, 1 = m1
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

    logic        granted, sel_m1, g_valid, done, wd_fire, rsp_ready;
    logic [31:0] rsp_rdata;

    // Grant decode, bus mux, completion/watchdog detection and response routing.
    always_comb begin
        granted = (state_q == GNT0) || (state_q == GNT1);
        sel_m1  = (state_q == GNT1);
        g_valid = granted && (sel_m1 ? m1_mem_valid_i : m0_mem_valid_i);
        done    = g_valid && s_mem_ready_i;
        // A slave ready in the expiry cycle takes precedence over the watchdog.
        wd_fire = WD_EN && g_valid && !s_mem_ready_i && (cnt_q == TO_VAL);

        s_mem_valid_o = g_valid && !wd_fire;
        s_mem_instr_o = 1'b0;
        s_mem_addr_o  = 32'h0;
        s_mem_wdata_o = 32'h0;
        s_mem_wstrb_o = 4'h0;
        if (granted) begin
            s_mem_instr_o = sel_m1 ? m1_mem_instr_i : m0_mem_instr_i;
            s_mem_addr_o  = sel_m1 ? m1_mem_addr_i  : m0_mem_addr_i;
            s_mem_wdata_o = sel_m1 ? m1_mem_wdata_i : m0_mem_wdata_i;
            s_mem_wstrb_o = sel_m1 ? m1_mem_wstrb_i : m0_mem_wstrb_i;
        end

        // No ready escapes during a reset cycle: the transfer is abandoned, not completed.
        rsp_ready = !rst_i && (done || wd_fire);
        rsp_rdata = wd_fire ? 32'h0 : s_mem_rdata_i;

        m0_mem_ready_o = (state_q == GNT0) && rsp_ready;
        m0_mem_rdata_o = (state_q == GNT0) ? rsp_rdata : 32'h0;
        m1_mem_ready_o = (state_q == GNT1) && rsp_ready;
        m1_mem_rdata_o = (state_q == GNT1) ? rsp_rdata : 32'h0;

        grant_o   = {state_q == GNT1, state_q == GNT0};
        busy_o    = |grant_o;
        timeout_o = wd_fire && !rst_i;
    end

    // Next-state: round-robin pick in IDLE, locked grant until ready, withdraw or watchdog.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (m0_mem_valid_i && m1_mem_valid_i) begin
                    state_d = last_q ? GNT0 : GNT1;
                end else if (m0_mem_valid_i) begin
                    state_d = GNT0;
                end else if (m1_mem_valid_i) begin
                    state_d = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (!g_valid || s_mem_ready_i || wd_fire) begin
                    state_d = IDLE;
                    last_d  = sel_m1;
                    cnt_d   = '0;
                end else if (WD_EN && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, last-served and watchdog registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
